// File: rtl/dot_relu_serializer.sv
// Captures a dot-product result vector, applies bias with saturation and ReLU,
// then streams the elements out one per cycle over a valid/ready handshake.
module dot_relu_serializer #(
  parameter int HID_LENGTH = 8,
  parameter int BIT_LENGTH = 16,
  parameter int IDX_W      = $clog2(HID_LENGTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [HID_LENGTH*BIT_LENGTH-1:0] in_data,
  input  logic [HID_LENGTH*BIT_LENGTH-1:0] bias_in,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIT_LENGTH-1:0]            out_data,
  output logic [IDX_W-1:0]                 out_idx,
  output logic                             out_last,
  output logic                             overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HID_LENGTH - 1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 overflow_reg;
  logic                 capture;
  logic [BIT_LENGTH-1:0] vec_reg   [HID_LENGTH];
  logic [BIT_LENGTH-1:0] proc_elem [HID_LENGTH];

  generate
    for (genvar gi = 0; gi < HID_LENGTH; gi++) begin : gen_elem
      logic signed [BIT_LENGTH:0] sum;
      logic [BIT_LENGTH-1:0]      in_elem, bias_elem;

      assign in_elem   = in_data[gi*BIT_LENGTH +: BIT_LENGTH];
      assign bias_elem = bias_in[gi*BIT_LENGTH +: BIT_LENGTH];
      assign sum = $signed({in_elem[BIT_LENGTH-1], in_elem}) +
                   $signed({bias_elem[BIT_LENGTH-1], bias_elem});

      // Any negative sum (saturated or not) is clamped to 0 by ReLU, so only
      // positive overflow needs an explicit saturation value.
      always_comb begin
        proc_elem[gi] = sum[BIT_LENGTH-1:0];
        if (sum[BIT_LENGTH]) begin
          proc_elem[gi] = '0;
        end else if (sum[BIT_LENGTH-1]) begin
          proc_elem[gi] = {1'b0, {(BIT_LENGTH-1){1'b1}}};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vec_reg[gi] <= '0;
        end else if (capture) begin
          vec_reg[gi] <= proc_elem[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (in_valid && !in_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    out_valid  = (state_reg == SEND);
    out_last   = out_valid && (idx_reg == LAST_IDX);
    // A new vector may be accepted on the same edge as the final transfer.
    in_ready   = (state_reg == IDLE) || (out_valid && out_ready && out_last);
    capture    = in_valid && in_ready;
    if (capture) begin
      state_next = SEND;
      idx_next   = '0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state_next = IDLE;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  assign out_data = out_valid ? vec_reg[idx_reg] : '0;
  assign out_idx  = idx_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_dot_relu_serializer.sv
// Directed bench for dot_relu_serializer: streaming, saturation, backpressure,
// back-to-back capture, overflow and asynchronous mid-stream reset.
module tb_dot_relu_serializer;

  localparam int N = 8;
  localparam int B = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [N*B-1:0] in_data;
  logic [N*B-1:0] bias_in;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [B-1:0]   out_data;
  logic [2:0]     out_idx;
  logic           out_last;
  logic           overflow;

  int checks = 0;
  int errors = 0;
  int d_arr [N];
  int b_arr [N];
  int exp_arr [N];

  always #5 clk = ~clk;

  dot_relu_serializer #(.HID_LENGTH(N), .BIT_LENGTH(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .bias_in(bias_in), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .overflow(overflow)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_vec();
    for (int i = 0; i < N; i++) begin
      in_data[i*B +: B] = d_arr[i][B-1:0];
      bias_in[i*B +: B] = b_arr[i][B-1:0];
    end
    in_valid = 1'b1;
  endtask

  // Called at the negedge where element 0 of a vector is first presented.
  task automatic stream(input int stall_idx, input int stall_n, input bit b2b,
                        input int ovf_at, input int stop_at);
    int xfers = 0;
    for (int k = 0; k < N; k++) begin
      if (k == stop_at) return;
      check("valid", int'(out_valid), 1);
      check("idx", int'(out_idx), k);
      check("data", int'(out_data), exp_arr[k]);
      check("last", int'(out_last), (k == N-1) ? 1 : 0);
      $display("xfer idx=%0d data=%0d", out_idx, out_data);
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("stall_valid", int'(out_valid), 1);
          check("stall_idx", int'(out_idx), k);
          check("stall_data", int'(out_data), exp_arr[k]);
        end
        out_ready = 1'b1;
      end
      if (k == ovf_at) begin
        for (int i = 0; i < N; i++) begin d_arr[i] = 1000; b_arr[i] = 0; end
        drive_vec();
        check("busy_in_ready", int'(in_ready), 0);
      end
      if (k == N-1 && b2b) begin
        check("last_in_ready", int'(in_ready), 1);
        drive_vec();
      end
      xfers++;
      @(negedge clk);
      in_valid = 1'b0;
      if (k == ovf_at) check("overflow_set", int'(overflow), 1);
    end
    check("xfer_count", xfers, N);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; bias_in = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_idx", int'(out_idx), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic stream
    d_arr = '{3, -5, 0, 7, -1, 100, 2, 9};
    b_arr = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_arr = '{3, 0, 0, 7, 0, 100, 2, 9};
    drive_vec();
    @(negedge clk);
    in_valid = 1'b0;
    stream(-1, 0, 1'b0, -1, -1);
    check("idle_valid", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
    @(negedge clk);
    check("idle_valid2", int'(out_valid), 0);

    // Bias and saturation
    d_arr = '{32000, -32768, 10, -3, 0, 0, 0, 0};
    b_arr = '{1000, -1, -4, 5, 0, 0, 0, 0};
    exp_arr = '{32767, 0, 6, 2, 0, 0, 0, 0};
    drive_vec();
    @(negedge clk);
    in_valid = 1'b0;
    stream(-1, 0, 1'b0, -1, -1);

    // Backpressure at idx 2
    d_arr = '{11, 22, 33, 44, 55, 66, 77, 88};
    b_arr = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_arr = '{12, 23, 34, 45, 56, 67, 78, 89};
    drive_vec();
    @(negedge clk);
    in_valid = 1'b0;
    stream(2, 3, 1'b0, -1, -1);
    check("bp_idle", int'(out_valid), 0);

    // Back-to-back: second vector offered on the idx 7 transfer
    d_arr = '{3, -5, 0, 7, -1, 100, 2, 9};
    b_arr = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_arr = '{3, 0, 0, 7, 0, 100, 2, 9};
    drive_vec();
    @(negedge clk);
    in_valid = 1'b0;
    d_arr = '{-100, 50, -7, 8, 32767, -32768, 1, 0};
    b_arr = '{0, 0, 10, 0, 1, 0, -1, 0};
    stream(-1, 0, 1'b1, -1, -1);
    exp_arr = '{0, 50, 3, 8, 32767, 0, 0, 0};
    stream(-1, 0, 1'b0, -1, -1);
    check("b2b_overflow", int'(overflow), 0);
    check("b2b_idle", int'(out_valid), 0);

    // Overflow: vector offered at idx 3 of a vector in flight
    d_arr = '{11, 22, 33, 44, 55, 66, 77, 88};
    b_arr = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_arr = '{12, 23, 34, 45, 56, 67, 78, 89};
    drive_vec();
    @(negedge clk);
    in_valid = 1'b0;
    stream(-1, 0, 1'b0, 3, -1);
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_no_extra", int'(out_valid), 0);
    @(negedge clk);
    check("ovf_no_extra2", int'(out_valid), 0);

    // Asynchronous reset at idx 4
    d_arr = '{3, -5, 0, 7, -1, 100, 2, 9};
    b_arr = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_arr = '{3, 0, 0, 7, 0, 100, 2, 9};
    drive_vec();
    @(negedge clk);
    in_valid = 1'b0;
    exp_arr = '{11, 22, 33, 44, 55, 66, 77, 88};
    exp_arr = '{3, 0, 0, 7, 0, 100, 2, 9};
    stream(-1, 0, 1'b0, -1, 4);
    check("pre_rst_idx", int'(out_idx), 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_idx", int'(out_idx), 0);
    check("arst_data", int'(out_data), 0);
    check("arst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_in_ready", int'(in_ready), 1);
      check("post_rst_valid", int'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_relu_serializer.md
Name: dot_relu_serializer

Overview:
- Downstream stage of the dot-product engine (main_dotv2).
- Captures the HID_LENGTH-wide result vector on the engine's valid pulse, adds a per-element bias with signed saturation, and applies ReLU.
- Streams the results out one element per cycle over a valid/ready handshake to the next layer or buffer.
- Holds one captured vector and detects results dropped while it is busy.

Parameters:
- HID_LENGTH, 8: number of elements in the input vector; must be ≥2.
- BIT_LENGTH, 16: element width, signed two's complement.
- IDX_W, $clog2(HID_LENGTH): width of the element index output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result-vector valid; wired to main_dotv2 valid.
- in_data  input  HID_LENGTH*BIT_LENGTH  result vector; element i = in_data[i*BIT_LENGTH +: BIT_LENGTH].
- bias_in  input  HID_LENGTH*BIT_LENGTH  bias vector, same packing, signed; sampled together with in_data.
- in_ready  output  1  capture possible this cycle (combinational).
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the element.
- out_data  output  BIT_LENGTH  ReLU(sat(in + bias)) for element out_idx.
- out_idx  output  IDX_W  index of the current element.
- out_last  output  1  high when out_idx == HID_LENGTH-1 and out_valid is high.
- overflow  output  1  sticky flag: a vector was offered while in_ready was low.

Behaviour:
- Reset (asynchronous, any time including mid-stream):
  - State goes to IDLE.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, overflow = 0.
  - The captured vector is discarded.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SEND: out_valid = 1; out_data and out_idx reflect the element index counter.
- Capture:
  - On a rising edge with in_valid && in_ready, all HID_LENGTH elements are processed and registered in one step.
  - Per element: sum = sign-extended in (BIT_LENGTH+1 bits) + sign-extended bias.
  - Saturate the sum to [-2^(BIT_LENGTH-1), 2^(BIT_LENGTH-1)-1], then clamp negative results to 0.
  - The index counter resets to 0 and the state goes to SEND.
- Latency: the cycle after capture has out_valid = 1, out_idx = 0, out_data = element 0.
- Transfer:
  - An element transfers on an edge where out_valid && out_ready; the index then increments.
  - While out_ready = 0, out_data, out_idx and out_last hold stable. out_valid never drops without a transfer.
- Last element:
  - The transfer of idx HID_LENGTH-1 ends the vector.
  - If in_valid is also high that cycle, the new vector is captured on the same edge and the state stays SEND with idx 0. There is no bubble.
  - Otherwise the state returns to IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is combinational from state and out_ready.
- in_valid while in_ready = 0: the vector is dropped, the stored vector is unaffected, and overflow is set to 1. overflow clears only on reset.
- in_valid in consecutive cycles while IDLE: the first vector is captured; later ones are dropped and set overflow (in_ready is low in SEND unless on the last transfer).
- The index counter wraps only through capture; it never exceeds HID_LENGTH-1.
- Single clock domain; no combinational path from in_data to outputs.

Test Plan:
- Basic stream:
  - Stimulus: after reset release, one in_valid pulse with elements {0:3, 1:-5, 2:0, 3:7, 4:-1, 5:100, 6:2, 7:9}, bias all 0, out_ready held 1.
  - Response: starting the next cycle, 8 consecutive outputs 3, 0, 0, 7, 0, 100, 2, 9 with idx 0..7; out_last only at idx 7; then IDLE.
- Bias and saturation:
  - Stimulus: element 0 = 32000 with bias 1000; element 1 = -32768 with bias -1; element 2 = 10 with bias -4; element 3 = -3 with bias 5.
  - Response: outputs 32767, 0, 6, 2.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles while idx = 2.
  - Response: out_valid stays 1; out_data and idx 2 are held for all 3 cycles; the stream resumes at idx 3 with no element lost or duplicated; the total is still 8 transfers.
- Back-to-back vectors:
  - Stimulus: a second in_valid asserted in the same cycle as the idx 7 transfer.
  - Response: the next cycle shows idx 0 of the second vector with no gap; overflow stays 0.
- Overflow:
  - Stimulus: in_valid pulsed at idx 3 of a vector in flight.
  - Response: overflow goes to 1 the next cycle and stays 1; the current vector completes unchanged; no extra outputs appear.
- Reset mid-stream:
  - Stimulus: rst_n driven low asynchronously at idx 4.
  - Response: out_valid, out_idx, out_data and overflow go to 0 immediately without waiting for a clock edge; after release the block is in IDLE with in_ready = 1 and emits nothing until the next in_valid.
